// File: rtl/mmio_pwm_led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_pwm_led_pkg
// Description : Shared register offsets and CTRL bit positions for the
//               mmio_pwm_led peripheral.
//               Offsets are relative to BASE_ADDR. STATUS sits directly after
//               the DUTY bank, so its offset depends on the channel count and
//               is provided as a function.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_pwm_led_pkg;

    localparam int OFF_ON    = 0;
    localparam int OFF_CTRL  = 1;
    localparam int OFF_PRESC = 2;
    localparam int OFF_DUTY0 = 3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_INV  = 1;
    localparam int CTRL_IRQE = 2;

    // STATUS follows the last DUTY register.
    function automatic int off_status(input int channels);
        return OFF_DUTY0 + channels;
    endfunction

endpackage : mmio_pwm_led_pkg
`default_nettype wire

// File: rtl/mmio_pwm_led_if.sv
`default_nettype none
// ============================================================================
// Module      : mmio_pwm_led_if
// Description : CPU read/write bus for the mmio_pwm_led peripheral.
//               write/read : single-cycle requests from the CPU
//               address    : register address (ADDR_W)
//               wdata      : write data (DATA_W)
//               rdata      : read data, valid with rvalid (DATA_W)
//               rvalid     : read data valid, one cycle after read
//               Modports: master (CPU side), slave (peripheral side).
// Revision    : 1.0 - initial release
// ============================================================================
interface mmio_pwm_led_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (
        output write, read, address, wdata,
        input  rdata, rvalid
    );

    modport slave (
        input  write, read, address, wdata,
        output rdata, rvalid
    );
endinterface : mmio_pwm_led_if
`default_nettype wire

// File: rtl/mmio_pwm_led_channel.sv
`default_nettype none
// ============================================================================
// Module      : pwm_channel
// Description : One PWM output channel. Holds the CPU-visible shadow duty and
//               the active duty used by the comparator. The active duty only
//               changes when load is high (period wrap, or global disable),
//               which keeps every period glitch-free.
// Ports       : clk, rst_n     - clock, async active-low reset
//               duty_we        - shadow duty write strobe
//               duty_wdata     - new shadow duty
//               load           - copy shadow into active duty this edge
//               cnt            - shared PWM counter
//               on, en, inv    - channel enable, global enable, invert
//               shadow         - shadow duty for read-back
//               pwm_out        - registered channel output
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_channel #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             duty_we,
    input  logic [PWM_W-1:0] duty_wdata,
    input  logic             load,
    input  logic [PWM_W-1:0] cnt,
    input  logic             on,
    input  logic             en,
    input  logic             inv,
    output logic [PWM_W-1:0] shadow,
    output logic             pwm_out
);

    logic [PWM_W-1:0] r_active;
    logic             w_raw;

    // All-ones is treated as 100% so the output never drops for one count.
    assign w_raw = on & en & ((r_active == {PWM_W{1'b1}}) | (cnt < r_active));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow   <= '0;
            r_active <= '0;
            pwm_out  <= 1'b0;
        end else begin
            if (duty_we) begin
                shadow <= duty_wdata;
            end
            // Non-blocking read of shadow: a same-edge write is deferred.
            if (load) begin
                r_active <= shadow;
            end
            pwm_out <= w_raw ^ inv;
        end
    end

endmodule : pwm_channel
`default_nettype wire

// File: rtl/mmio_pwm_led.sv
`default_nettype none
// ============================================================================
// Module      : mmio_pwm_led
// Description : Memory-mapped multi-channel PWM LED/GPIO output peripheral.
//               Register map (offset from BASE_ADDR):
//                 0 ON, 1 CTRL (EN, INV, IRQE), 2 PRESC,
//                 3..3+CHANNELS-1 DUTY[i], 3+CHANNELS STATUS (WRAP, W1C).
//               A shared prescaler and PWM counter drive CHANNELS
//               pwm_channel instances.
// Ports       : clk, rst_n - clock, async active-low reset
//               bus        - CPU read/write bus (slave modport)
//               pwm_out    - registered channel outputs
//               irq        - registered WRAP & IRQE (MMIO_PWM_LED_IRQ_EN only)
// Options     : MMIO_PWM_LED_IRQ_EN - adds irq port and CTRL.IRQE bit.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_pwm_led
    import mmio_pwm_led_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int BASE_ADDR = 128,
    parameter int CHANNELS  = 3,
    parameter int PWM_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    mmio_pwm_led_if.slave       bus,
    output logic [CHANNELS-1:0] pwm_out
`ifdef MMIO_PWM_LED_IRQ_EN
    ,
    output logic                irq
`endif
);

    localparam logic [ADDR_W-1:0] c_BASE     = ADDR_W'(BASE_ADDR);
    localparam int                c_NUM_REGS = off_status(CHANNELS) + 1;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] w_off;
    logic              w_hit;
    logic              w_wr_on;
    logic              w_wr_ctrl;
    logic              w_wr_presc;
    logic              w_wr_status;
    logic [CHANNELS-1:0] w_duty_we;

    assign w_off       = bus.address - c_BASE;
    assign w_hit       = (bus.address >= c_BASE) && (w_off < ADDR_W'(c_NUM_REGS));
    assign w_wr_on     = bus.write & w_hit & (w_off == ADDR_W'(OFF_ON));
    assign w_wr_ctrl   = bus.write & w_hit & (w_off == ADDR_W'(OFF_CTRL));
    assign w_wr_presc  = bus.write & w_hit & (w_off == ADDR_W'(OFF_PRESC));
    assign w_wr_status = bus.write & w_hit & (w_off == ADDR_W'(off_status(CHANNELS)));

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] r_on;
    logic                r_en;
    logic                r_inv;
    logic [DATA_W-1:0]   r_presc;
`ifdef MMIO_PWM_LED_IRQ_EN
    logic                r_irqe;
    logic                w_irqe_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_on    <= '0;
            r_en    <= 1'b0;
            r_inv   <= 1'b0;
            r_presc <= '0;
`ifdef MMIO_PWM_LED_IRQ_EN
            r_irqe  <= 1'b0;
`endif
        end else begin
            if (w_wr_on) begin
                r_on <= bus.wdata[CHANNELS-1:0];
            end
            if (w_wr_ctrl) begin
                r_en   <= bus.wdata[CTRL_EN];
                r_inv  <= bus.wdata[CTRL_INV];
`ifdef MMIO_PWM_LED_IRQ_EN
                r_irqe <= bus.wdata[CTRL_IRQE];
`endif
            end
            if (w_wr_presc) begin
                r_presc <= bus.wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shared prescaler and PWM counter
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_presc_cnt;
    logic [PWM_W-1:0]  r_pwm_cnt;
    logic              w_tick;
    logic              w_wrap;

    assign w_tick = r_en & (r_presc_cnt == r_presc);
    assign w_wrap = w_tick & (r_pwm_cnt == {PWM_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc_cnt <= '0;
            r_pwm_cnt   <= '0;
        end else if (!r_en) begin
            r_presc_cnt <= '0;
            r_pwm_cnt   <= '0;
        end else begin
            // Reprogramming PRESC restarts the current prescale interval.
            if (w_wr_presc || w_tick) begin
                r_presc_cnt <= '0;
            end else begin
                r_presc_cnt <= r_presc_cnt + 1'b1;
            end
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // STATUS.WRAP: sticky, W1C, a coincident wrap wins over the clear
    // ------------------------------------------------------------------
    logic r_wrap;
    logic w_wrap_nxt;

    assign w_wrap_nxt = w_wrap | (r_wrap & ~(w_wr_status & bus.wdata[0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_nxt;
        end
    end

`ifdef MMIO_PWM_LED_IRQ_EN
    // Built from next-state values so irq always equals WRAP & IRQE.
    assign w_irqe_nxt = w_wr_ctrl ? bus.wdata[CTRL_IRQE] : r_irqe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= w_wrap_nxt & w_irqe_nxt;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    logic [PWM_W-1:0] w_shadow [CHANNELS];
    logic             w_load;

    // Disabled: active duties follow the shadows continuously.
    assign w_load = w_wrap | ~r_en;

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_channel
            assign w_duty_we[g] = bus.write & w_hit & (w_off == ADDR_W'(OFF_DUTY0 + g));

            pwm_channel #(
                .PWM_W (PWM_W)
            ) u_channel (
                .clk        (clk),
                .rst_n      (rst_n),
                .duty_we    (w_duty_we[g]),
                .duty_wdata (bus.wdata[PWM_W-1:0]),
                .load       (w_load),
                .cnt        (r_pwm_cnt),
                .on         (r_on[g]),
                .en         (r_en),
                .inv        (r_inv),
                .shadow     (w_shadow[g]),
                .pwm_out    (pwm_out[g])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read-back (registered, zero when not valid)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_rd_data;

    always_comb begin
        w_rd_data = '0;
        if (w_hit) begin
            if (w_off == ADDR_W'(OFF_ON)) begin
                w_rd_data[CHANNELS-1:0] = r_on;
            end
            if (w_off == ADDR_W'(OFF_CTRL)) begin
                w_rd_data[CTRL_EN]   = r_en;
                w_rd_data[CTRL_INV]  = r_inv;
`ifdef MMIO_PWM_LED_IRQ_EN
                w_rd_data[CTRL_IRQE] = r_irqe;
`endif
            end
            if (w_off == ADDR_W'(OFF_PRESC)) begin
                w_rd_data = r_presc;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_off == ADDR_W'(OFF_DUTY0 + i)) begin
                    w_rd_data = DATA_W'(w_shadow[i]);
                end
            end
            if (w_off == ADDR_W'(off_status(CHANNELS))) begin
                w_rd_data[0] = r_wrap;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
        end else if (bus.read) begin
            bus.rdata  <= w_rd_data;
            bus.rvalid <= 1'b1;
        end else begin
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
        end
    end

endmodule : mmio_pwm_led
`default_nettype wire

// File: tb/tb_mmio_pwm_led.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_pwm_led
// Description : Directed self-checking bench for mmio_pwm_led (3 channels,
//               8-bit bus and PWM, base address 128).
// Options     : MMIO_PWM_LED_IRQ_EN - also exercises the irq output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_pwm_led;

    localparam logic [7:0] c_A_ON     = 8'd128;
    localparam logic [7:0] c_A_CTRL   = 8'd129;
    localparam logic [7:0] c_A_PRESC  = 8'd130;
    localparam logic [7:0] c_A_DUTY0  = 8'd131;
    localparam logic [7:0] c_A_DUTY1  = 8'd132;
    localparam logic [7:0] c_A_STATUS = 8'd134;
    localparam logic [7:0] c_A_UNMAP  = 8'd137;
`ifdef MMIO_PWM_LED_IRQ_EN
    localparam logic [7:0] c_CTRL_RB  = 8'h07;
`else
    localparam logic [7:0] c_CTRL_RB  = 8'h03;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mmio_pwm_led_if #(.ADDR_W(8), .DATA_W(8)) bus ();
    logic [2:0] pwm_out;
`ifdef MMIO_PWM_LED_IRQ_EN
    logic irq;
`endif

    mmio_pwm_led #(
        .ADDR_W    (8),
        .DATA_W    (8),
        .BASE_ADDR (128),
        .CHANNELS  (3),
        .PWM_W     (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .pwm_out (pwm_out)
`ifdef MMIO_PWM_LED_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    int n_chk = 0;
    int n_err = 0;
    int h1, h2, h3;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.write   = 1'b1;
        bus.address = a;
        bus.wdata   = d;
        @(negedge clk);
        bus.write   = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
        @(negedge clk);
        bus.read    = 1'b1;
        bus.address = a;
        @(negedge clk);
        bus.read    = 1'b0;
        chk(tag, 32'(bus.rdata), 32'(exp));
        chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
    endtask

    // Disable, clear WRAP, program PRESC/DUTY0, then enable with ctrl.
    // Returns at the falling edge right after the enabling edge.
    task automatic restart(input logic [7:0] ctrl, input logic [7:0] presc, input logic [7:0] duty0);
        bus_write(c_A_CTRL, 8'h00);
        bus_write(c_A_STATUS, 8'h01);
        bus_write(c_A_PRESC, presc);
        bus_write(c_A_DUTY0, duty0);
        bus_write(c_A_CTRL, ctrl);
    endtask

    // Counts ch0 high samples in nwin windows of win cycles. When wr_k > 1
    // a single write of wd to wa lands on enable-edge + wr_k.
    task automatic run_win(input int wr_k, input logic [7:0] wa, input logic [7:0] wd,
                           input int win, input int nwin,
                           output int c1, output int c2, output int c3);
        c1 = 0;
        c2 = 0;
        c3 = 0;
        for (int k = 1; k <= win * nwin; k++) begin
            @(negedge clk);
            if (pwm_out[0]) begin
                if (k <= win)          c1++;
                else if (k <= 2 * win) c2++;
                else                   c3++;
            end
            if (k == wr_k - 1) begin
                bus.write   = 1'b1;
                bus.address = wa;
                bus.wdata   = wd;
            end else begin
                bus.write   = 1'b0;
            end
        end
        bus.write = 1'b0;
    endtask

    initial begin
        bus.write   = 1'b0;
        bus.read    = 1'b0;
        bus.address = 8'd0;
        bus.wdata   = 8'd0;

        // Power-on reset
        repeat (3) @(negedge clk);
        chk("rst_pwm",    32'(pwm_out),    32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_rdata",  32'(bus.rdata),  32'd0);
        rst_n = 1'b1;

        // Basic read-back and one-cycle rvalid
        bus_write(c_A_ON, 8'h05);
        bus_read(c_A_ON, 8'h05, "on_rd");
        @(negedge clk);
        chk("rvalid_drop", 32'(bus.rvalid), 32'd0);
        chk("rdata_idle",  32'(bus.rdata),  32'd0);

        // Duty patterns, PRESC=0, only ch0 on
        bus_write(c_A_ON, 8'h01);
        restart(8'h01, 8'd0, 8'd64);
        run_win(0, 8'd0, 8'd0, 256, 1, h1, h2, h3);
        chk("duty64", h1, 64);
        chk("ch12_off", 32'(pwm_out[2:1]), 32'd0);
        restart(8'h01, 8'd0, 8'd0);
        run_win(0, 8'd0, 8'd0, 256, 1, h1, h2, h3);
        chk("duty0", h1, 0);
        restart(8'h01, 8'd0, 8'd255);
        run_win(0, 8'd0, 8'd0, 256, 1, h1, h2, h3);
        chk("duty255", h1, 256);

        // Mid-period duty write: current period keeps the old duty
        restart(8'h01, 8'd0, 8'd64);
        run_win(100, c_A_DUTY0, 8'd200, 256, 3, h1, h2, h3);
        chk("mid_p1", h1, 64);
        chk("mid_p2", h2, 200);
        chk("mid_p3", h3, 200);

        // Write on the wrap edge: deferred one full period
        restart(8'h01, 8'd0, 8'd64);
        run_win(256, c_A_DUTY0, 8'd200, 256, 3, h1, h2, h3);
        chk("wrapw_p1", h1, 64);
        chk("wrapw_p2", h2, 64);
        chk("wrapw_p3", h3, 200);

        // Prescaler: duty 1 is high while pwm_cnt==0 (4 cycles at PRESC=3)
        restart(8'h01, 8'd3, 8'd1);
        run_win(0, 8'd0, 8'd0, 20, 1, h1, h2, h3);
        chk("presc_hold", h1, 4);
        // Rewriting PRESC two cycles in stretches pwm_cnt==0 to 6 cycles
        restart(8'h01, 8'd3, 8'd1);
        run_win(2, c_A_PRESC, 8'd3, 20, 1, h1, h2, h3);
        chk("presc_restart", h1, 6);
        bus_read(c_A_PRESC, 8'd3, "presc_rd");

        // Invert with prescale: 1024-cycle period, 256 raw-high cycles
        restart(8'h03, 8'd3, 8'd64);
        run_win(0, 8'd0, 8'd0, 1024, 1, h1, h2, h3);
        chk("inv_period", h1, 768);
        chk("inv_off_ch", 32'(pwm_out[2:1]), 32'd3);

        // Asynchronous reset mid-run
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_pwm",    32'(pwm_out),    32'd0);
        chk("mid_rst_rvalid", 32'(bus.rvalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(c_A_ON,    8'd0, "on_after_rst");
        bus_read(c_A_CTRL,  8'd0, "ctrl_after_rst");
        bus_read(c_A_DUTY0, 8'd0, "duty_after_rst");

        // Disabled with INV: all outputs high
        bus_write(c_A_CTRL, 8'h02);
        @(negedge clk);
        chk("inv_idle", 32'(pwm_out), 32'd7);
        bus_write(c_A_CTRL, 8'h00);

        // Decode: unmapped write ignored, unmapped reads are 0
        bus_write(c_A_ON, 8'h02);
        bus_write(c_A_UNMAP, 8'hFF);
        bus_read(c_A_UNMAP, 8'h00, "unmap_rd");
        bus_read(8'd127, 8'h00, "below_base_rd");
        bus_read(c_A_ON, 8'h02, "on_kept");
        bus_read(c_A_PRESC, 8'h00, "presc_kept");

        // Simultaneous read and write of DUTY1
        bus_write(c_A_DUTY1, 8'h11);
        @(negedge clk);
        bus.read    = 1'b1;
        bus.write   = 1'b1;
        bus.address = c_A_DUTY1;
        bus.wdata   = 8'h22;
        @(negedge clk);
        bus.read    = 1'b0;
        bus.write   = 1'b0;
        chk("rw_old", 32'(bus.rdata), 32'h11);
        bus_read(c_A_DUTY1, 8'h22, "rw_new");

        // STATUS.WRAP
        bus_write(c_A_ON, 8'h01);
        restart(8'h01, 8'd0, 8'd0);
        run_win(0, 8'd0, 8'd0, 100, 1, h1, h2, h3);
        bus_read(c_A_STATUS, 8'h00, "wrap_pre");
        run_win(0, 8'd0, 8'd0, 200, 1, h1, h2, h3);
        bus_read(c_A_STATUS, 8'h01, "wrap_set");
        bus_write(c_A_CTRL, 8'h00);
        bus_write(c_A_STATUS, 8'h01);
        bus_read(c_A_STATUS, 8'h00, "wrap_clr");

        // Clear on the wrap edge: set wins; a later clear works
        restart(8'h01, 8'd0, 8'd0);
        run_win(256, c_A_STATUS, 8'h01, 257, 1, h1, h2, h3);
        bus_read(c_A_STATUS, 8'h01, "wrap_vs_clr");
        bus_write(c_A_STATUS, 8'h01);
        bus_read(c_A_STATUS, 8'h00, "wrap_clr_run");

`ifdef MMIO_PWM_LED_IRQ_EN
        restart(8'h05, 8'd0, 8'd0);
        run_win(0, 8'd0, 8'd0, 257, 1, h1, h2, h3);
        chk("irq_set", 32'(irq), 32'd1);
        bus_write(c_A_STATUS, 8'h01);
        chk("irq_clr", 32'(irq), 32'd0);
`endif

        // CTRL read-back of unused / optional bits
        bus_write(c_A_CTRL, 8'h07);
        bus_read(c_A_CTRL, c_CTRL_RB, "ctrl_rb");
        bus_write(c_A_CTRL, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_mmio_pwm_led
`default_nettype wire

// File: doc/mmio_pwm_led.md
Name: mmio_pwm_led

Overview:
- Memory-mapped, parametrised LED/GPIO output peripheral on the CPU read/write bus.
- Replaces the single fixed on/off LED register with CHANNELS independent outputs.
- Each output has an on bit, an 8-bit-class PWM duty, and a shared programmable prescaler.
- Duty updates are glitch-free and take effect at period boundaries; read-back is registered.

Parameters:
- ADDR_W, 8, bus address width
- DATA_W, 8, bus data width; must be >= CHANNELS and >= PWM_W
- BASE_ADDR, 128, address of register 0
- CHANNELS, 3, number of PWM outputs (1..DATA_W)
- PWM_W, 8, PWM counter/duty width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- write  in  1  CPU write request, single-cycle
- read  in  1  CPU read request, single-cycle
- address  in  ADDR_W  read/write address
- wdata  in  DATA_W  write data from CPU
- rdata  out  DATA_W  read data to CPU, valid with rvalid
- rvalid  out  1  read data valid, one cycle after read
- pwm_out  out  CHANNELS  channel outputs, registered

Behaviour:
- Register map (offset from BASE_ADDR; unmapped offsets ignore writes and read 0):
  - 0 ON: bit i enables channel i.
  - 1 CTRL: bit0 EN (global enable), bit1 INV (invert all outputs).
  - 2 PRESC: prescaler reload value.
  - 3..3+CHANNELS-1 DUTY[i]: low PWM_W bits used; upper bits read 0.
  - 3+CHANNELS STATUS: bit0 WRAP, sticky; write 1 to clear.
- Reset: all registers 0, active duties 0, counters 0, rdata=0, rvalid=0, pwm_out=0.
  - INV=0 after reset, so outputs are low.
  - Reset mid-period aborts immediately.
- Reads:
  - rdata and rvalid are registered and appear the cycle after read.
  - rdata=0 whenever rvalid=0; never X.
  - A read of DUTY returns the shadow (last-written) value.
- Writes:
  - Take effect on the clock edge where write=1.
  - write and read together to the same address: the read returns the pre-write value.
- Prescaler:
  - presc_cnt counts 0..PRESC; tick=1 when presc_cnt==PRESC, then presc_cnt returns to 0.
  - PRESC=0 gives a tick every cycle.
  - A write to PRESC clears presc_cnt the same edge.
- PWM counter:
  - pwm_cnt (PWM_W bits) increments on tick and wraps from 2^PWM_W-1 to 0.
  - The wrap sets STATUS.WRAP.
  - On the wrap edge, every active duty loads from its shadow, using the shadow value before any same-cycle write. A duty written on the wrap edge takes effect the following period.
  - While EN=0: pwm_cnt and presc_cnt are held at 0, active duties track the shadows every cycle, and pwm_out = {CHANNELS{INV}}.
- Output: raw_i = ON[i] & EN & ((duty_i == all-ones) | (pwm_cnt < duty_i)); pwm_out_i = raw_i ^ INV.
  - duty 0 means 0%; all-ones means 100%.
  - Output is registered, one cycle after pwm_cnt.
- STATUS.WRAP: set and clear on the same edge → set wins.

Optional Feature:
- Macro: MMIO_PWM_LED_IRQ_EN.
- Defined:
  - Adds port irq, out, 1.
  - Adds CTRL bit2 IRQE.
  - irq is registered = STATUS.WRAP & IRQE; it deasserts the cycle after a W1C clear.
- Undefined: no irq port; CTRL bit2 reads 0 and ignores writes.

Decomposition:
- Package mmio_pwm_led_pkg holds:
  - register offset localparams: OFF_ON, OFF_CTRL, OFF_PRESC, OFF_DUTY0, and OFF_STATUS as a function of CHANNELS;
  - CTRL bit indices.
- One sub-module, pwm_channel (per-channel shadow/active duty and compare), instantiated CHANNELS times via generate.
- Prescaler and pwm_cnt stay in the top level, shared by all channels.

Test Plan:
- Reset and read-back: assert rst_n=0 mid-run → pwm_out=0, rdata=0. Then write ON=0x05, read addr 128 → rdata=0x05 with rvalid exactly one cycle later.
- Duty pattern: PRESC=0, EN=1, ON=0x01, DUTY0=64 → ch0 high for 64 of every 256 cycles. DUTY0=0 → constant 0. DUTY0=255 → constant 1.
- Glitch-free update: write DUTY0=200 mid-period while active duty is 64 → current period keeps 64 high cycles, next period has 200. Repeat with the write on the exact wrap edge → change is deferred one period.
- Prescale and invert: PRESC=3, INV=1 → pwm_cnt advances every 4 cycles and the output is inverted. Write PRESC mid-count → presc_cnt restarts at 0.
- Decode and simultaneous access: write to 128+9 → no state change, read returns 0. Simultaneous read+write of DUTY1 → old value returned, new value on the next read.
- STATUS / IRQ (IRQ_EN defined): IRQE=1, wait for a wrap → WRAP=1 and irq=1. Write 0x01 to STATUS → irq drops the next cycle. Clear coincident with a wrap → WRAP stays 1.
